// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : State encoding and fixed constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam logic [1:0] ST_VEC_HI = 2'd0;
  localparam logic [1:0] ST_VEC_LO = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_EXT    = 2'd3;

  // Opword bit that marks a 32-bit instruction (immediate word follows)
  localparam int IMM_FLAG_BIT   = 0;
  localparam int RESET_VEC_ADDR = 0;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Loads the start PC from the reset vector, then streams 16/32-bit
//               instructions to decode, honouring stalls and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int WORD_LENGTH   = 16,
  parameter int ADDRESS_SPACE = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_SPACE-1:0] mar,
  input  logic [WORD_LENGTH-1:0]   mdr,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_SPACE-1:0] redirect_pc,
  output logic [2*WORD_LENGTH-1:0] instr,
  output logic [ADDRESS_SPACE-1:0] instr_pc,
  output logic                     instr_valid
);

  logic [1:0]             r_state;
  logic [WORD_LENGTH-1:0] r_vec_hi;
  logic [WORD_LENGTH-1:0] r_op_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_VEC_HI;
      mar         <= ADDRESS_SPACE'(RESET_VEC_ADDR);
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      r_vec_hi    <= '0;
      r_op_hold   <= '0;
    end else begin
      case (r_state)
        ST_VEC_HI: begin
          r_vec_hi    <= mdr;
          mar         <= ADDRESS_SPACE'(RESET_VEC_ADDR + 1);
          instr_valid <= 1'b0;
          r_state     <= ST_VEC_LO;
        end
        ST_VEC_LO: begin
          // Start PC is the low ADDRESS_SPACE bits of the two vector words
          mar         <= ADDRESS_SPACE'({r_vec_hi, mdr});
          instr_valid <= 1'b0;
          r_state     <= ST_FETCH;
        end
        default: begin
          if (redirect) begin
            mar         <= redirect_pc;
            instr_valid <= 1'b0;
            r_op_hold   <= '0;
            r_state     <= ST_FETCH;
          end else if (!stall) begin
            if (r_state == ST_EXT) begin
              instr       <= {r_op_hold, mdr};
              instr_pc    <= mar - 1'b1;
              instr_valid <= 1'b1;
              mar         <= mar + 1'b1;
              r_state     <= ST_FETCH;
            end else if (mdr[IMM_FLAG_BIT]) begin
              r_op_hold   <= mdr;
              instr_valid <= 1'b0;
              mar         <= mar + 1'b1;
              r_state     <= ST_EXT;
            end else begin
              instr       <= {mdr, {WORD_LENGTH{1'b0}}};
              instr_pc    <= mar;
              instr_valid <= 1'b1;
              mar         <= mar + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench: memory model, expected-output queue, vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int WL = 16;
  localparam int AS = 21;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [AS-1:0]   redirect_pc = '0;
  logic [AS-1:0]   mar;
  logic [AS-1:0]   instr_pc;
  logic [WL-1:0]   mdr;
  logic [2*WL-1:0] instr;
  logic            instr_valid;

  always #5 clk = ~clk;

  instr_fetch_unit #(.WORD_LENGTH(WL), .ADDRESS_SPACE(AS)) dut (
    .clk(clk), .reset(reset), .mar(mar), .mdr(mdr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  logic [WL-1:0] mem [logic [AS-1:0]];

  typedef struct {
    logic [2*WL-1:0] instr;
    logic [AS-1:0]   pc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [WL-1:0]   op;
    logic [WL-1:0]   imm;
    int              nwords;
    logic [2*WL-1:0] exp_instr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int total_cyc = 0;
  int rel_cyc = 0;
  int last_pop_cyc = 0;

  function automatic logic [WL-1:0] mem_rd(input logic [AS-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Memory answers half a cycle after mar moves; undriven while in reset
  always @(negedge clk) begin
    #1;
    mdr = reset ? mem_rd(mar) : 'z;
  end

  always @(posedge clk) total_cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A new output is one produced at an edge that was neither stalled nor redirected
  always @(posedge clk) begin : monitor
    logic s_stall, s_redir, s_reset;
    exp_t e;
    s_stall = stall;
    s_redir = redirect;
    s_reset = reset;
    #1;
    if (s_reset && !s_stall && !s_redir && instr_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_instr", instr, e.instr);
      chk("sb_instr_pc", instr_pc, e.pc);
      last_pop_cyc = total_cyc;
    end
  end

  task automatic start_reset(input logic [WL-1:0] vhi, input logic [WL-1:0] vlo);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    chk("rst_mar", mar, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    exp_q.delete();
    mem.delete();
    mem[0] = vhi;
    mem[1] = vlo;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    rel_cyc = total_cyc;
  endtask

  task automatic drain(input string name, input int exp_last);
    repeat (200) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_last_cycle"}, last_pop_cyc - rel_cyc, exp_last);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    vec_t tbl[8];
    logic [AS-1:0] a;
    int len;

    // Vector load and short stream
    start_reset(16'h0000, 16'h0040);
    mem[21'h40] = 16'h1000; mem[21'h41] = 16'h2000; mem[21'h42] = 16'h3000;
    exp_q.push_back('{32'h1000_0000, 21'h40});
    exp_q.push_back('{32'h2000_0000, 21'h41});
    exp_q.push_back('{32'h3000_0000, 21'h42});
    release_reset();
    #1 chk("vec_mar_c1", mar, 0);
    @(posedge clk); #1 chk("vec_mar_c2", mar, 1);
    @(posedge clk); #1 chk("vec_mar_c3", mar, 21'h40);
    drain("short", 5);

    // Mixed table, entered by reset from a running stream
    tbl[0] = '{16'h1000, 16'h0000, 1, 32'h1000_0000};
    tbl[1] = '{16'h5001, 16'hABCD, 2, 32'h5001_ABCD};
    tbl[2] = '{16'h2000, 16'h0000, 1, 32'h2000_0000};
    tbl[3] = '{16'h7FFF, 16'h0001, 2, 32'h7FFF_0001};
    tbl[4] = '{16'hFFFE, 16'h0000, 1, 32'hFFFE_0000};
    tbl[5] = '{16'h0003, 16'hFFFF, 2, 32'h0003_FFFF};
    tbl[6] = '{16'h8000, 16'h0000, 1, 32'h8000_0000};
    tbl[7] = '{16'h3002, 16'h0000, 1, 32'h3002_0000};
    start_reset(16'h0000, 16'h0123);
    a = 21'h123;
    len = 0;
    for (int i = 0; i < 8; i++) begin
      mem[a] = tbl[i].op;
      if (tbl[i].nwords == 2) mem[a + 21'd1] = tbl[i].imm;
      exp_q.push_back('{tbl[i].exp_instr, a});
      a = a + 21'(tbl[i].nwords);
      len += tbl[i].nwords;
    end
    release_reset();
    drain("table", 2 + len);

    // Single long instruction
    start_reset(16'h0000, 16'h0040);
    mem[21'h40] = 16'h5001; mem[21'h41] = 16'hABCD;
    exp_q.push_back('{32'h5001_ABCD, 21'h40});
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("long_gap_valid", instr_valid, 0);
    chk("long_gap_mar", mar, 21'h41);
    @(posedge clk); #1 chk("long_next_mar", mar, 21'h42);
    drain("long", 4);

    // Three-cycle stall in FETCH
    start_reset(16'h0000, 16'h0040);
    for (int i = 0; i < 6; i++) begin
      mem[21'h40 + 21'(i)] = 16'((i + 1) << 12);
      exp_q.push_back('{32'((i + 1) << 28), 21'h40 + 21'(i)});
    end
    release_reset();
    repeat (4) @(posedge clk);
    @(negedge clk) stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_mar", mar, 21'h42);
      chk("stall_instr", instr, 32'h2000_0000);
      chk("stall_valid", instr_valid, 1);
    end
    @(negedge clk) stall = 1'b0;
    drain("stall", 11);

    // Redirect while in EXT with stall asserted
    start_reset(16'h0000, 16'h0040);
    mem[21'h40] = 16'h5001; mem[21'h41] = 16'hABCD;
    mem[21'h100] = 16'h4000; mem[21'h101] = 16'h9001; mem[21'h102] = 16'h0042;
    exp_q.push_back('{32'h4000_0000, 21'h100});
    exp_q.push_back('{32'h9001_0042, 21'h101});
    release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 21'h100;
    @(posedge clk); #1;
    chk("redir_valid", instr_valid, 0);
    chk("redir_mar", mar, 21'h100);
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    drain("redirect", 7);

    // Truncated vector to the top word, immediate fetched across the wrap
    start_reset(16'hFFFF, 16'hFFFF);
    mem[21'h1F_FFFF] = 16'h7001;
    exp_q.push_back('{32'h7001_1234, 21'h1F_FFFF});
    release_reset();
    @(posedge clk); #1 chk("wrap_mar_c2", mar, 1);
    mem[0] = 16'h1234;
    @(posedge clk); #1 chk("wrap_mar_c3", mar, 21'h1F_FFFF);
    @(posedge clk); #1 chk("wrap_mar_ext", mar, 0);
    @(posedge clk); #1 chk("wrap_next_mar", mar, 1);
    drain("wrap", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-stage initiator for the instruction memory: drives the word address (MAR), captures the returned word (MDR) and assembles 16-bit or 32-bit instructions for the decode stage. After reset, it loads the start PC from the reset vector in words 0–1. It handles decode-stage stalls and branch/jump redirects. It sits between the PC/hazard logic and the IF/ID pipeline register.

## Interface
- WORD_LENGTH, 16, memory word width
- ADDRESS_SPACE, 21, word-address width

- clk  in  1  processor clock; the memory reads on negedge, this block acts on posedge
- reset  in  1  reset, synchronous, active-low
- mar  out  ADDRESS_SPACE  word address to instruction memory
- mdr  in  WORD_LENGTH  word returned by memory
- stall  in  1  hold fetch; IF/ID cannot accept
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  ADDRESS_SPACE  redirect target
- instr  out  2*WORD_LENGTH  assembled instruction {opword, immword}; immword = 0 for short instructions
- instr_pc  out  ADDRESS_SPACE  address of the opword of `instr`
- instr_valid  out  1  `instr` / `instr_pc` valid this cycle

## Operation
- The memory presents `mem[mar]` on `mdr` at the negedge following a posedge update of `mar`. This block samples `mdr` at the next posedge.
- An opword with bit 0 = 1 is a 32-bit instruction; its immediate word follows at `mar+1`.
- States: VEC_HI, VEC_LO, FETCH, EXT.
- Reset (reset=0 at posedge):
  - state ← VEC_HI
  - mar, instr, instr_pc, vec_hi, op_hold ← 0
  - instr_valid ← 0
  - While reset is low, `mdr` is undefined (Z) and is never sampled.
- VEC_HI: vec_hi ← mdr; mar ← 1; → VEC_LO.
- VEC_LO: mar ← {vec_hi, mdr}[ADDRESS_SPACE-1:0]; → FETCH. The address is truncated and the upper bits are dropped.
- `stall` and `redirect` are ignored in VEC_HI and VEC_LO.
- FETCH / EXT rules, in priority order:
  1. redirect=1: mar ← redirect_pc; instr_valid ← 0; op_hold discarded; → FETCH. This applies even if stall=1.
  2. stall=1: all registers hold, including instr_valid, instr and instr_pc.
  3. FETCH, mdr[0]=0:
     - instr ← {mdr, 0}
     - instr_pc ← mar
     - instr_valid ← 1
     - mar ← mar+1
  4. FETCH, mdr[0]=1: op_hold ← mdr; instr_valid ← 0; mar ← mar+1; → EXT.
  5. EXT:
     - instr ← {op_hold, mdr}
     - instr_pc ← mar−1
     - instr_valid ← 1
     - mar ← mar+1
     - → FETCH
- Arithmetic: all mar/pc arithmetic is modulo 2^ADDRESS_SPACE. 0x1FFFFF+1 wraps to 0, including an immediate word at the wrap point.

## Timing
- Reset release: mar=0 in cycle 1, mar=1 in cycle 2, mar=start PC in cycle 3. The first instr_valid occurs at the posedge ending cycle 3 (short opword) or cycle 4 (long opword).
- Throughput: 1 short instruction per cycle; 1 long instruction per 2 cycles.
- Redirect latency: redirect sampled at posedge N → mar=target after N. The target instruction is valid after N+1 (short) or N+2 (long).
- Redirect at the same edge as a would-be valid output: the output is suppressed (instr_valid=0).
- Reset mid-operation: behaves as reset from any state; the vector is reloaded.
- instr_valid stays registered while stalled, so downstream sees the same instruction until stall drops.

## Structure
- Shared package: state encoding (2 bits), IMM_FLAG_BIT=0, RESET_VEC_ADDR=0.
- Single module; no sub-module is warranted.

## Test plan
- Reset-vector load: mem[0]=0x0000, mem[1]=0x0040. After reset release, mar sequence is 0,1,0x40.
- Short-instruction stream: mem[0x40..0x42]=0x1000,0x2000,0x3000. instr is 0x10000000, 0x20000000, 0x30000000 on consecutive cycles, with instr_pc 0x40, 0x41, 0x42.
- Long instruction: mem[0x40]=0x5001, mem[0x41]=0xABCD. instr_valid is 0 for one cycle, then instr=0x5001ABCD with instr_pc=0x40; the next mar is 0x42.
- Stall: assert stall for 3 cycles in FETCH. mar, instr and instr_valid are frozen. Release → the stream resumes with no lost or duplicated instruction.
- Redirect in EXT with stall=1, redirect_pc=0x100. op_hold is dropped, no valid output is produced, and mar=0x100. The next instr_pc is 0x100.
- Wrap: vector = 0x1FFFFF with mem[0x1FFFFF]=0x7001, mem[0]=0x1234. instr=0x70011234, instr_pc=0x1FFFFF, next mar=1.
